// File: rtl/number_hit_controller.sv
// Latches player/number collisions over a frame and issues at most one one-hot
// hit per frame boundary, with optional post-hit cooldown and collection tracking.
module number_hit_controller #(
  parameter int NUMBERS         = 3,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               levelRestart,
  input  logic               playerDR,
  input  logic [NUMBERS-1:0] numbersDR,
  output logic [NUMBERS-1:0] singleHit,
  output logic [NUMBERS-1:0] collected,
  output logic [COUNT_W-1:0] hitCount,
  output logic               allCollected
);

  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  typedef enum logic {ARMED, COOLDOWN} state_t;

  state_t             state, state_n;
  logic [CD_W-1:0]    cooldownCnt, cooldownCnt_n;
  logic [NUMBERS-1:0] frameHits, frameHits_n;
  logic [NUMBERS-1:0] singleHit_n, collected_n;
  logic [COUNT_W-1:0] hitCount_n;
  logic               allCollected_n;
  logic [NUMBERS-1:0] collide, lowest;

  assign collide = {NUMBERS{playerDR}} & numbersDR & ~collected;
  assign lowest  = frameHits & (~frameHits + NUMBERS'(1));

  always_comb begin
    state_n        = state;
    cooldownCnt_n  = cooldownCnt;
    frameHits_n    = frameHits | collide;
    singleHit_n    = '0;
    collected_n    = collected;
    hitCount_n     = hitCount;
    allCollected_n = &collected;

    if (startOfFrame) begin
      unique case (state)
        ARMED: begin
          if (frameHits != '0) begin
            singleHit_n = lowest;
            collected_n = collected | lowest;
            if (hitCount != '1)
              hitCount_n = hitCount + COUNT_W'(1);
            if (COOLDOWN_FRAMES > 0) begin
              cooldownCnt_n = CD_W'(COOLDOWN_FRAMES);
              state_n       = COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          cooldownCnt_n = cooldownCnt - CD_W'(1);
          if (cooldownCnt == CD_W'(1))
            state_n = ARMED;
        end
        default: state_n = ARMED;
      endcase
      // A number collected by this very evaluation must not seed the new frame.
      frameHits_n = collide & ~collected_n;
    end

    if (levelRestart) begin
      state_n        = ARMED;
      cooldownCnt_n  = '0;
      frameHits_n    = '0;
      singleHit_n    = '0;
      collected_n    = '0;
      hitCount_n     = '0;
      allCollected_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ARMED;
      cooldownCnt  <= '0;
      frameHits    <= '0;
      singleHit    <= '0;
      collected    <= '0;
      hitCount     <= '0;
      allCollected <= 1'b0;
    end else begin
      state        <= state_n;
      cooldownCnt  <= cooldownCnt_n;
      frameHits    <= frameHits_n;
      singleHit    <= singleHit_n;
      collected    <= collected_n;
      hitCount     <= hitCount_n;
      allCollected <= allCollected_n;
    end
  end

endmodule

// File: tb/tb_number_hit_controller.sv
// Directed vector bench for number_hit_controller: main table on the default
// configuration, plus async-reset and counter-saturation sequences.
module tb_number_hit_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, rst, pdr;
  logic [2:0] ndr;
  logic [2:0] hit, col;
  logic [7:0] cnt;
  logic       all;

  logic       sof2, rst2, pdr2;
  logic [3:0] ndr2, hit2, col2;
  logic [1:0] cnt2;
  logic       all2;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  number_hit_controller #(.NUMBERS(3), .COOLDOWN_FRAMES(2), .COUNT_W(8)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .levelRestart(rst),
    .playerDR(pdr), .numbersDR(ndr), .singleHit(hit), .collected(col),
    .hitCount(cnt), .allCollected(all)
  );

  number_hit_controller #(.NUMBERS(4), .COOLDOWN_FRAMES(0), .COUNT_W(2)) dut_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(sof2), .levelRestart(rst2),
    .playerDR(pdr2), .numbersDR(ndr2), .singleHit(hit2), .collected(col2),
    .hitCount(cnt2), .allCollected(all2)
  );

  typedef struct {
    logic       sof;
    logic       rst;
    logic       pdr;
    logic [2:0] ndr;
    logic [2:0] hit;
    logic [2:0] col;
    logic [7:0] cnt;
    logic       all;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic r, input logic p, input logic [2:0] n,
                     input logic [2:0] h, input logic [2:0] c, input logic [7:0] k,
                     input logic a);
    vec_t v;
    v.sof = s; v.rst = r; v.pdr = p; v.ndr = n;
    v.hit = h; v.col = c; v.cnt = k; v.all = a;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input int idx, input logic [2:0] h,
                          input logic [2:0] c, input logic [7:0] k, input logic a);
    chk({tag, ".singleHit"}, idx, 32'(hit), 32'(h));
    chk({tag, ".collected"}, idx, 32'(col), 32'(c));
    chk({tag, ".hitCount"}, idx, 32'(cnt), 32'(k));
    chk({tag, ".allCollected"}, idx, 32'(all), 32'(a));
  endtask

  initial begin
    resetN = 1'b0;
    sof = 0; rst = 0; pdr = 0; ndr = '0;
    sof2 = 0; rst2 = 0; pdr2 = 0; ndr2 = '0;

    // single hit, then cooldown over two frames, then hit on number 0
    for (int i = 0; i < 4; i++) add(0, 0, 1, 3'b010, 3'b000, 3'b000, 0, 0);
    add(0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    add(1, 0, 0, 3'b000, 3'b010, 3'b010, 1, 0);
    add(0, 0, 0, 3'b000, 3'b000, 3'b010, 1, 0);
    add(0, 0, 1, 3'b001, 3'b000, 3'b010, 1, 0);
    add(1, 0, 0, 3'b000, 3'b000, 3'b010, 1, 0);
    add(0, 0, 1, 3'b001, 3'b000, 3'b010, 1, 0);
    add(1, 0, 0, 3'b000, 3'b000, 3'b010, 1, 0);
    add(0, 0, 1, 3'b011, 3'b000, 3'b010, 1, 0);
    add(1, 0, 0, 3'b000, 3'b001, 3'b011, 2, 0);
    add(0, 0, 0, 3'b000, 3'b000, 3'b011, 2, 0);
    // already-collected number 1 keeps colliding, through cooldown and after
    for (int i = 0; i < 3; i++) begin
      add(0, 0, 1, 3'b010, 3'b000, 3'b011, 2, 0);
      add(1, 0, 0, 3'b000, 3'b000, 3'b011, 2, 0);
    end
    // collect number 2 -> all collected one cycle later
    add(0, 0, 1, 3'b100, 3'b000, 3'b011, 2, 0);
    add(1, 0, 0, 3'b000, 3'b100, 3'b111, 3, 0);
    add(0, 0, 0, 3'b000, 3'b000, 3'b111, 3, 1);
    add(0, 1, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    // simultaneous collisions: lowest index wins
    add(0, 0, 1, 3'b101, 3'b000, 3'b000, 0, 0);
    add(1, 0, 0, 3'b000, 3'b001, 3'b001, 1, 0);
    add(0, 0, 0, 3'b000, 3'b000, 3'b001, 1, 0);
    add(1, 0, 0, 3'b000, 3'b000, 3'b001, 1, 0);
    add(1, 0, 0, 3'b000, 3'b000, 3'b001, 1, 0);
    // restart together with startOfFrame and a pending hit
    add(0, 0, 1, 3'b100, 3'b000, 3'b001, 1, 0);
    add(1, 1, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    add(1, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    // collision only on the frame-edge pixel belongs to the new frame
    add(1, 0, 1, 3'b010, 3'b000, 3'b000, 0, 0);
    add(0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    add(1, 0, 0, 3'b000, 3'b010, 3'b010, 1, 0);
    add(0, 0, 0, 3'b000, 3'b000, 3'b010, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 0, 3'b000, 3'b000, 8'd0, 1'b0);
    resetN = 1'b1;

    foreach (vecs[i]) begin
      sof = vecs[i].sof; rst = vecs[i].rst; pdr = vecs[i].pdr; ndr = vecs[i].ndr;
      cyc();
      chk_main("vec", i, vecs[i].hit, vecs[i].col, vecs[i].cnt, vecs[i].all);
    end

    // async reset mid-cooldown with a pending collision
    sof = 0; rst = 0; pdr = 1; ndr = 3'b001;
    cyc();
    pdr = 0; ndr = '0;
    #2 resetN = 1'b0;
    #1 chk_main("async_rst", 0, 3'b000, 3'b000, 8'd0, 1'b0);
    @(negedge clk) resetN = 1'b1;
    sof = 1;
    cyc();
    chk_main("post_rst_sof", 0, 3'b000, 3'b000, 8'd0, 1'b0);
    sof = 0; pdr = 1; ndr = 3'b001;
    cyc();
    sof = 1; pdr = 0; ndr = '0;
    cyc();
    chk_main("post_rst_hit", 0, 3'b001, 3'b001, 8'd1, 1'b0);
    sof = 0;
    cyc();
    chk("post_rst_pulse_len", 0, 32'(hit), 32'd0);

    // saturating counter, no cooldown: hits on consecutive frames
    for (int i = 0; i < 4; i++) begin
      pdr2 = 1; ndr2 = 4'(1 << i);
      cyc();
      pdr2 = 0; ndr2 = '0; sof2 = 1;
      cyc();
      sof2 = 0;
      chk("sat.singleHit", i, 32'(hit2), 32'(1 << i));
      chk("sat.hitCount", i, 32'(cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    cyc();
    chk("sat.collected", 0, 32'(col2), 32'hF);
    chk("sat.allCollected", 0, 32'(all2), 32'd1);
    chk("sat.singleHit_idle", 0, 32'(hit2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
